// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART transmitter.
package uart_pkg;

  localparam int UART_DEFAULT_DIVISOR = 104;
  localparam int UART_DEFAULT_DEPTH   = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO queueing bytes for the UART transmitter; DEPTH must be a power of two.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                         raw_clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // A pop in the same cycle frees the slot a write into a full queue needs.
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; entries are only read after a push wrote them.
  always_ff @(posedge raw_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for 8E1 framing.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIVISOR    = UART_DEFAULT_DIVISOR,
  parameter int FIFO_DEPTH = UART_DEFAULT_DEPTH
) (
  input  logic                              raw_clk,
  input  logic                              reset_n,
  input  logic                              write_enable,
  input  logic [7:0]                        data_in,
  input  logic                              clear_overflow,
  output logic                              tx,
  output logic                              busy,
  output logic                              fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow
);

  localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 1);

  uart_state_e state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        bit_end;
  logic        pop;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;

  assign bit_end = (baud_cnt == '0);
  // STOP pops on its last cycle so the next start bit follows with no idle gap.
  assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .raw_clk (raw_clk),
    .reset_n (reset_n),
    .push    (write_enable),
    .wr_data (data_in),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (write_enable && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge raw_clk) begin
    if (!reset_n)  parity_bit <= 1'b0;
    else if (pop)  parity_bit <= even_parity(fifo_rd_data);
  end
`endif

  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift_reg <= fifo_rd_data;
            baud_cnt  <= BAUD_RELOAD;
            tx        <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift_reg <= fifo_rd_data;
              baud_cnt  <= BAUD_RELOAD;
              tx        <= 1'b0;
              state     <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered 8N1 UART transmitter for the memory-mapped peripheral space. It sits directly downstream of the peripheral register decoder: the decoder forwards CPU stores on the UART data register as one-cycle write strobes. Bytes are queued in a small FIFO and serialized LSB-first on `tx`. The decoder reads the status outputs back as a register.

## Interface
- `DIVISOR`, 104: `raw_clk` cycles per bit (12 MHz / 115200 baud); legal range 2..65535.
- `FIFO_DEPTH`, 8: queue entries; must be a power of two, ≥2.
- `raw_clk` in 1: the single clock; all logic on posedge.
- `reset_n` in 1: reset, synchronous, active-low.
- `write_enable` in 1: one-cycle strobe; push `data_in` into the FIFO.
- `data_in` in 8: byte to transmit.
- `clear_overflow` in 1: one-cycle strobe; clears `overflow`.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high while a frame is on the line.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `fifo_count` out $clog2(FIFO_DEPTH+1): entries queued, excluding the byte being shifted.
- `overflow` out 1: sticky; set when a write is dropped.

## Operation
- Reset (`reset_n`=0 at an edge) sets all outputs and state:
  - `tx`=1, `busy`=0, `fifo_count`=0, `fifo_full`=0, `overflow`=0, state IDLE, FIFO pointers 0.
- Reset mid-frame aborts the frame: the line returns high immediately and the queue is discarded.
- FIFO write: if `write_enable` and not full, store `data_in` at the write pointer and increment the pointer mod `FIFO_DEPTH`.
- FIFO full, no pop in the same cycle: the byte is dropped and `overflow` is set.
- Write and pop in the same cycle when full: the pop frees a slot, the write is accepted, and `overflow` is not set.
- Write and pop in the same cycle otherwise: `fifo_count` is unchanged.
- `overflow` precedence: `clear_overflow` and a new overflow in the same cycle leaves `overflow`=1 (set wins).
- State machine:
  - IDLE: `tx`=1, `busy`=0. If the FIFO is non-empty, pop into `shift_reg`, load the bit counter with `DIVISOR-1`, and go to START.
  - START: `tx`=0 for `DIVISOR` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=`shift_reg[0]` for `DIVISOR` cycles per bit, shifting right after each bit. After 8 bits go to PARITY if compiled in, else to STOP.
  - PARITY: `tx`= XOR of the 8 data bits (even parity) for `DIVISOR` cycles, then go to STOP.
  - STOP: `tx`=1 for `DIVISOR` cycles. Then, if the FIFO is non-empty, pop and go straight to START (back-to-back frames with no idle gap); otherwise go to IDLE.
- `busy`=1 in START, DATA, PARITY and STOP.
- Baud counter: 16-bit down-counter, reloaded with `DIVISOR-1` on each bit boundary; the bit ends when the counter reaches 0.

## Timing
- `write_enable` at edge N into an empty FIFO while IDLE:
  - `fifo_count`=1 after N.
  - Pop at N+1; `tx`=0 and `busy`=1 after N+1; `fifo_count`=0 after N+1.
- Frame length is exactly 10·`DIVISOR` cycles, or 11·`DIVISOR` with parity.
- `tx` is driven from a flop: no combinational path from any input.
- Status outputs are registered and valid the cycle after the causing edge.

## Configuration
- `UART_TX_PARITY_EN` defined: adds the PARITY state and an even-parity bit (8E1, 11 bits per frame).
- `UART_TX_PARITY_EN` undefined: PARITY state and parity logic are absent; frame is 8N1, 10 bits.
- Ports are identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - state typedef (IDLE, START, DATA, PARITY, STOP)
  - `UART_DEFAULT_DIVISOR` = 104
  - `UART_DEFAULT_DEPTH` = 8
- One sub-module, `uart_fifo`: parameterized synchronous FIFO with push/pop/full/empty/count. It has no knowledge of framing.
- `uart_tx` holds the state machine, baud counter and shift register.

## Test plan
- Reset mid-frame: `DIVISOR`=4; drive `reset_n` low at cycle 10 of a frame → `tx`=1, `busy`=0, `fifo_count`=0 after that edge.
- Single byte: `DIVISOR`=4, write 0x55 → `tx` low from N+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 of 4 cycles each, then high; `busy` drops after 40 cycles (44 with parity; parity bit 0).
- Back-to-back: write 0xA3 then 0x0F on consecutive cycles → two frames with no idle cycle between STOP and START; the second start bit begins exactly 40 cycles after the first.
- Overflow: `FIFO_DEPTH`=8, `DIVISOR`=100, 10 consecutive writes → the first byte is popped at once, the next 8 fill the queue, and the 10th is dropped. Expect `fifo_full`=1, `overflow`=1, `fifo_count`=8. Then pulse `clear_overflow` → `overflow`=0.
- Simultaneous write/pop at full: fill to 8 and time a write to coincide with the STOP→START pop → `fifo_count` stays 8 and `overflow` stays 0.
- Parity build, 0x07 → parity bit 1.
